// File: rtl/config_pkg.sv
// Shared types and constants for the configuration bitstream loader.
package config_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } cfg_state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8, MSB-first, no final XOR. Only built when CONFIG_LOADER_CRC_EN is defined.
`ifdef CONFIG_LOADER_CRC_EN
module crc8_serial
    import config_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       bit_en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic fb_c;

    assign fb_c = crc[7] ^ bit_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC8_INIT;
        end else if (clr) begin
            crc <= CRC8_INIT;
        end else if (bit_en) begin
            crc <= {crc[6:0], 1'b0} ^ (fb_c ? CRC8_POLY : 8'h00);
        end
    end

endmodule
`endif

// File: rtl/config_loader.sv
// Serializes configuration words MSB-first into the LE scan chain while masking the fabric.
// Optional CRC-8 trailer check is enabled by defining CONFIG_LOADER_CRC_EN.
module config_loader
    import config_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 17,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              config_data_in,
    output logic              chain_en,
    output logic              config_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WB_W  = $clog2(WORD_W);

    cfg_state_t        state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WB_W-1:0]   wbit_q, wbit_d;
    logic              err_d;
    logic              hold_q, hold_d;

`ifdef CONFIG_LOADER_CRC_EN
    logic [7:0] crc_val;
    logic       crc_clr_c;

    assign crc_clr_c = (state_q == ST_IDLE) && start;

    crc8_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr_c),
        .bit_en (chain_en),
        .bit_in (config_data_in),
        .crc    (crc_val)
    );
`endif

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        wbit_d    = wbit_q;
        err_d     = err;
        hold_d    = hold_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    err_d     = 1'b0;
                    hold_d    = 1'b0;
                    bit_cnt_d = '0;
                    wbit_d    = '0;
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    shift_d = word_in;
                    wbit_d  = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d   = {shift_q[WORD_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                wbit_d    = wbit_q + WB_W'(1);
                if (bit_cnt_d == CNT_W'(CHAIN_LEN)) begin
`ifdef CONFIG_LOADER_CRC_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else if (wbit_q == WB_W'(WORD_W - 1)) begin
                    state_d = ST_LOAD;
                end
            end
`ifdef CONFIG_LOADER_CRC_EN
            ST_CHECK: begin
                if (word_valid) begin
                    if (word_in[7:0] == crc_val) begin
                        state_d = ST_DONE;
                    end else begin
                        // Bad bitstream: stay masked until the next start
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                    end
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            hold_d  = 1'b0;
        end
    end

    // State and registered outputs, decoded from next-state values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            wbit_q         <= '0;
            hold_q         <= 1'b0;
            err            <= 1'b0;
            word_ready     <= 1'b0;
            config_data_in <= 1'b0;
            chain_en       <= 1'b0;
            config_en      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            wbit_q         <= wbit_d;
            hold_q         <= hold_d;
            err            <= err_d;
            word_ready     <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
            chain_en       <= (state_d == ST_SHIFT);
            config_data_in <= (state_d == ST_SHIFT) ? shift_d[WORD_W-1] : 1'b0;
            config_en      <= (state_d == ST_LOAD) || (state_d == ST_SHIFT) ||
                              (state_d == ST_CHECK) || hold_d;
            busy           <= (state_d != ST_IDLE);
            done           <= (state_d == ST_DONE);
        end
    end

endmodule
